// File: rtl/apple_spawner.sv
// apple_spawner: sequential front end for the combinational apple-position
// selector. It steps a 16-bit Galois LFSR, scales it into a cell index seed,
// waits one cycle for the selector to settle, and re-checks that the returned
// cell is empty before it publishes a registered apple position.
//
// Optional feature (macro APPLE_SPAWNER_SEED_LOAD_EN): adds seed_load and
// seed_value so that the LFSR can be reseeded at any edge.
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   rst        synchronous active-high reset
//   req        spawn request, sampled only in IDLE
//   field      packed playfield, 3 bits per cell, 3'd0 = empty
//   sel_pos    position returned by the selector for the current seed
//   seed       registered seed driven to the selector
//   apple_pos  registered spawned position
//   valid      one-cycle pulse: apple_pos is new
//   full       one-cycle pulse: no empty cell found, no apple spawned
//   busy       high in every state except IDLE
//   seed_load  (macro only) load seed_value into the LFSR
//   seed_value (macro only) new LFSR value, 0 is replaced by 16'hACE1
module apple_spawner #(
  parameter int unsigned SIZE_X     = 10,
  parameter int unsigned SIZE_Y     = 10,
  parameter int unsigned FIELD_SIZE = (SIZE_X * SIZE_Y) * 3,
  parameter int unsigned SBITS      = $clog2(SIZE_X * SIZE_Y),
  parameter int unsigned MAX_TRIES  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic [FIELD_SIZE-1:0] field,
  input  logic [SBITS-1:0]      sel_pos,
`ifdef APPLE_SPAWNER_SEED_LOAD_EN
  input  logic                  seed_load,
  input  logic [15:0]           seed_value,
`endif
  output logic [SBITS-1:0]      seed,
  output logic [SBITS-1:0]      apple_pos,
  output logic                  valid,
  output logic                  full,
  output logic                  busy
);

  localparam int unsigned N        = SIZE_X * SIZE_Y;
  localparam int unsigned PW       = 16 + SBITS;
  localparam int unsigned TW       = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [15:0] LFSR_RST = 16'hACE1;
  localparam logic [15:0] LFSR_TAP = 16'hB400;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_WAIT  = 2'd2,
    S_CHECK = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [TW-1:0]    try_q, try_d;
  logic [SBITS-1:0] seed_q, seed_d;
  logic [SBITS-1:0] apple_q, apple_d;
  logic             valid_q, valid_d;
  logic             full_q, full_d;
  logic             busy_q, busy_d;

  logic             any_free;
  logic             sel_free;
  logic [15:0]      lfsr_step;
  logic [PW-1:0]    seed_prod;
  logic [SBITS-1:0] seed_scaled;

  // Any empty cell anywhere in the field
  always_comb begin
    any_free = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      if (field[i*3 +: 3] == 3'd0) any_free = 1'b1;
    end
  end

  // Selector result must be in range and still point at an empty cell
  always_comb begin
    sel_free = 1'b0;
    if (32'(sel_pos) < N) sel_free = (field[32'(sel_pos)*3 +: 3] == 3'd0);
  end

  // Galois right-shift step; a nonzero state never reaches zero
  assign lfsr_step = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAP : 16'h0000);

  // (lfsr * N) >> 16 lands in 0..N-1 without a modulo
  assign seed_prod   = PW'(lfsr_q) * PW'(N);
  assign seed_scaled = SBITS'(seed_prod >> 16);

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    try_d   = try_q;
    seed_d  = seed_q;
    apple_d = apple_q;
    valid_d = 1'b0;
    full_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        try_d = '0;
        if (req) state_d = S_LOAD;
      end
      S_LOAD: begin
        if (!any_free) begin
          full_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          seed_d  = seed_scaled;
          lfsr_d  = lfsr_step;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (sel_free) begin
          apple_d = sel_pos;
          valid_d = 1'b1;
          state_d = S_IDLE;
        end else if (try_q == TW'(MAX_TRIES - 1)) begin
          full_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          try_d   = try_q + TW'(1);
          state_d = S_LOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef APPLE_SPAWNER_SEED_LOAD_EN
    // External reseed overrides the LOAD step
    if (seed_load) lfsr_d = (seed_value == 16'h0000) ? LFSR_RST : seed_value;
`endif

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      lfsr_q  <= LFSR_RST;
      try_q   <= '0;
      seed_q  <= '0;
      apple_q <= '0;
      valid_q <= 1'b0;
      full_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      try_q   <= try_d;
      seed_q  <= seed_d;
      apple_q <= apple_d;
      valid_q <= valid_d;
      full_q  <= full_d;
      busy_q  <= busy_d;
    end
  end

  assign seed      = seed_q;
  assign apple_pos = apple_q;
  assign valid     = valid_q;
  assign full      = full_q;
  assign busy      = busy_q;

endmodule
